// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed seven-segment scan driver: shadowed digit data, per-digit DP/blank,
// leading-zero suppression and PWM brightness with a dark guard cycle per slot.
module sevseg_scan_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 50000,
    parameter int BRIGHT_W       = 4,
    parameter int ACTIVE_LOW_AN  = 1,
    parameter int ACTIVE_LOW_SEG = 1,
    localparam int IDX_W         = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    Rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_suppress,
    input  logic                    load,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              sev_out,
    output logic                    dp_out,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_done
);

    localparam int CNT_W   = $clog2(SCAN_DIV);
    localparam int ON_STEP = SCAN_DIV / (2**BRIGHT_W);

    logic [CNT_W-1:0]        r_slot_cnt;
    logic [IDX_W-1:0]        r_digit_idx;
    logic                    r_frame_done;
    logic                    r_pending;
    logic [4*NUM_DIGITS-1:0] r_sh_val;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank;
    logic                    r_sh_lz;
    logic [BRIGHT_W-1:0]     r_bright_q;
    logic [NUM_DIGITS-1:0]   r_an_on;
    logic [6:0]              r_seg_on;
    logic                    r_dp_on;

    logic                    w_slot_end;
    logic                    w_wrap;
    logic                    w_all_zero;
    logic [NUM_DIGITS-1:0]   w_supp;
    logic                    w_dark;
    logic [3:0]              w_nib;
    logic [CNT_W:0]          w_on_lim;
    logic                    w_lit;
    logic [NUM_DIGITS-1:0]   w_onehot;

    // Returns the active-low pattern {a..g}; the caller inverts to get "segment lit".
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    seg_decode = 7'b0000001;
            4'h1:    seg_decode = 7'b1001111;
            4'h2:    seg_decode = 7'b0010010;
            4'h3:    seg_decode = 7'b0000110;
            4'h4:    seg_decode = 7'b1001100;
            4'h5:    seg_decode = 7'b0100100;
            4'h6:    seg_decode = 7'b0100000;
            4'h7:    seg_decode = 7'b0001111;
            4'h8:    seg_decode = 7'b0000000;
            4'h9:    seg_decode = 7'b0000100;
            4'hA:    seg_decode = 7'b0001000;
            4'hB:    seg_decode = 7'b1100000;
            4'hC:    seg_decode = 7'b0110001;
            4'hD:    seg_decode = 7'b1000010;
            4'hE:    seg_decode = 7'b0110000;
            default: seg_decode = 7'b0111000;
        endcase
    endfunction

    assign w_slot_end = en && (r_slot_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_wrap     = w_slot_end && (r_digit_idx == IDX_W'(NUM_DIGITS - 1));

    // A digit is suppressed when it and every digit to its left hold zero.
    always_comb begin
        w_all_zero = 1'b1;
        w_supp     = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_all_zero = w_all_zero & (r_sh_val[4*k +: 4] == 4'h0);
            if (k != 0) begin
                w_supp[k] = r_sh_lz & w_all_zero;
            end
        end
    end

    assign w_nib    = r_sh_val[{r_digit_idx, 2'b00} +: 4];
    assign w_dark   = r_sh_blank[r_digit_idx] | w_supp[r_digit_idx];
    assign w_on_lim = (CNT_W+1)'((32'(r_bright_q) + 32'd1) * 32'(ON_STEP));
    assign w_lit    = en && (r_slot_cnt != '0) && ({1'b0, r_slot_cnt} < w_on_lim) && !w_dark;
    assign w_onehot = NUM_DIGITS'(1) << r_digit_idx;

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_slot_cnt   <= '0;
            r_digit_idx  <= '0;
            r_frame_done <= 1'b0;
            r_bright_q   <= '0;
        end else begin
            r_frame_done <= w_wrap;
            if (en) begin
                r_slot_cnt <= w_slot_end ? '0 : r_slot_cnt + 1'b1;
                if (r_slot_cnt == '0) begin
                    r_bright_q <= brightness;
                end
            end
            if (w_slot_end) begin
                r_digit_idx <= (r_digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_digit_idx + 1'b1;
            end
        end
    end

    // Shadow data only changes at the frame boundary so a frame never mixes old and new values.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pending  <= 1'b0;
            r_sh_val   <= '0;
            r_sh_dp    <= '0;
            r_sh_blank <= '0;
            r_sh_lz    <= 1'b0;
        end else if (w_wrap) begin
            r_pending <= 1'b0;
            if (r_pending || load) begin
                r_sh_val   <= value;
                r_sh_dp    <= dp;
                r_sh_blank <= blank_mask;
                r_sh_lz    <= lz_suppress;
            end
        end else if (load) begin
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_an_on  <= '0;
            r_seg_on <= '0;
            r_dp_on  <= 1'b0;
        end else begin
            r_an_on  <= w_lit ? w_onehot : '0;
            r_seg_on <= w_lit ? ~seg_decode(w_nib) : '0;
            r_dp_on  <= w_lit & r_sh_dp[r_digit_idx];
        end
    end

    assign an         = (ACTIVE_LOW_AN != 0)  ? ~r_an_on  : r_an_on;
    assign sev_out    = (ACTIVE_LOW_SEG != 0) ? ~r_seg_on : r_seg_on;
    assign dp_out     = (ACTIVE_LOW_SEG != 0) ? ~r_dp_on  : r_dp_on;
    assign digit_idx  = r_digit_idx;
    assign frame_done = r_frame_done;

endmodule

// File: doc/sevseg_scan_ctrl.md
Name: sevseg_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display driver for the board-level debug and MMIO display path. It replaces the fixed 8-digit scan logic with a configurable controller that adds:
- tear-free shadow loading
- per-digit decimal points and blanking
- leading-zero suppression
- PWM brightness with an anti-ghosting guard cycle

It sits between the display data source (debug_output / disp_out mux) and the board anode/segment pins.

Parameters:
- NUM_DIGITS, 8: number of digits scanned; 2..16.
- SCAN_DIV, 50000: clk cycles per digit slot; must be a multiple of 2**BRIGHT_W and at least 2*2**BRIGHT_W.
- BRIGHT_W, 4: brightness width. Localparam ON_STEP = SCAN_DIV / 2**BRIGHT_W.
- ACTIVE_LOW_AN, 1: 1 means an is active-low.
- ACTIVE_LOW_SEG, 1: 1 means sev_out and dp_out are active-low.

Ports:
- clk  in  1  system clock (single domain).
- Rst_n  in  1  asynchronous reset, active-low.
- en  in  1  scan enable.
- value  in  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i]; digit 0 is rightmost.
- dp  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- blank_mask  in  NUM_DIGITS  1 = force digit dark.
- lz_suppress  in  1  leading-zero suppression enable.
- load  in  1  request to capture value/dp/blank_mask/lz_suppress.
- brightness  in  BRIGHT_W  duty level; 0 = 1/2**BRIGHT_W, all-ones = full.
- an  out  NUM_DIGITS  one-hot anode select.
- sev_out  out  7  segments {a,b,c,d,e,f,g}.
- dp_out  out  1  decimal point segment.
- digit_idx  out  $clog2(NUM_DIGITS)  current slot index.
- frame_done  out  1  one-cycle pulse when digit_idx wraps to 0.

Behaviour:
- Reset (async, Rst_n=0):
  - slot_cnt=0, digit_idx=0, shadow registers=0, pending=0, frame_done=0.
  - an=all inactive, sev_out=all segments off, dp_out=off.
- Scan timing:
  - slot_cnt counts 0..SCAN_DIV-1 while en=1.
  - At SCAN_DIV-1, slot_cnt goes to 0 and digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
  - The frame_done register is set in the same cycle as that wrap, so the pulse is visible on the following cycle.
- en=0: slot_cnt and digit_idx hold, outputs go inactive next cycle, frame_done=0. Scanning resumes from the held position on en=1.
- Shadow load:
  - load=1 sets pending.
  - Shadow registers update from the live inputs only in the cycle digit_idx wraps to 0.
  - If load and the wrap coincide, capture happens that cycle using the current inputs; pending stays 0.
  - Multiple loads within one frame collapse to the inputs present at the wrap cycle.
  - The first frame after reset displays zeros unless load is asserted.
- Brightness: sampled into bright_q when slot_cnt==0. The digit drives when 1 <= slot_cnt < (bright_q+1)*ON_STEP.
  - slot_cnt==0 is a guard cycle with all anodes off, to prevent ghosting.
  - Maximum brightness is lit from cycle 1 to the end of the slot.
- Leading-zero suppression: when shadow lz=1, digit k is dark if every shadow nibble from NUM_DIGITS-1 down to k is 0. Digit 0 is never suppressed.
- A digit is dark if blank_mask or suppression applies. In that case sev_out and dp_out are off and an is inactive.
- Hex decode, active-low form (a = MSB): 0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000 7:0001111 8:0000000 9:0000100 A:0001000 b:1100000 C:0110001 d:1000010 E:0110000 F:0111000.
  - When ACTIVE_LOW_SEG=0, invert this pattern and dp_out.
  - When ACTIVE_LOW_AN=0, invert an.
- Latency: an/sev_out/dp_out are registered. They reflect the slot_cnt and digit_idx of the previous cycle.
- No combinational path from any input to any output.

Test Plan:
Bench parameters: NUM_DIGITS=4, SCAN_DIV=16, BRIGHT_W=2, ON_STEP=4.
1. Reset mid-scan: deassert Rst_n at slot_cnt=9 of digit 2 -> same cycle an=4'b1111, sev_out=7'b1111111, digit_idx=0. After release with en=1, the digit 0 slot begins.
2. Load value=16'h12AF, brightness=3, pulse load mid-frame -> old shadow is shown until the wrap. Next frame shows digit 0 as F (0111000) with an=4'b1110 lit for 15 cycles per slot, and frame_done pulses once per 64 cycles.
3. brightness=0 -> each digit is lit for exactly 3 cycles (slot_cnt 1..3, seen one cycle later on outputs). The guard cycle shows an=4'b1111.
4. value=16'h0070, lz_suppress=1 -> digits 3 and 2 stay dark, digit 1 shows 7, digit 0 shows 0. value=16'h0000 -> only digit 0 shows 0.
5. dp=4'b0100, blank_mask=4'b0001 -> dp_out=0 only during the digit 2 slot; digit 0 stays fully dark.
6. load asserted in the exact wrap cycle with value=16'hBEEF -> capture takes effect that frame. Drop en for 10 cycles -> outputs inactive and digit_idx held; scan resumes from the held position.
